// File: rtl/pacman_map_pkg.sv
// Shared map geometry, direction and FSM encodings for sprite movement and rendering.
package pacman_map_pkg;

    localparam int TILE_SHIFT = 4;
    localparam int IDX_X_W    = 7;
    localparam int IDX_Y_W    = 6;
    localparam int POS_X_W    = 11;
    localparam int POS_Y_W    = 10;

    typedef enum logic [2:0] {
        DIR_N,
        DIR_S,
        DIR_E,
        DIR_W,
        DIR_NONE
    } dir_e;

    typedef enum logic {
        ST_IDLE,
        ST_MOVE
    } state_e;

endpackage

// File: rtl/sprite_tile_mover_map_index_to_display_pos.sv
// Tile index to top-left display pixel; inverse of the display-to-map-index path.
module sprite_tile_mover_map_index_to_display_pos
    import pacman_map_pkg::*;
#(
    parameter int TILE_SHIFT = pacman_map_pkg::TILE_SHIFT
) (
    input  logic [IDX_X_W-1:0] idx_x,
    input  logic [IDX_Y_W-1:0] idx_y,
    output logic [POS_X_W-1:0] pos_x,
    output logic [POS_Y_W-1:0] pos_y
);

    assign pos_x = POS_X_W'(idx_x) << TILE_SHIFT;
    assign pos_y = POS_Y_W'(idx_y) << TILE_SHIFT;

endmodule

// File: rtl/sprite_tile_mover.sv
// Steps one sprite pixel-by-pixel toward an adjacent target tile.
// Optional SPRITE_TUNNEL_WRAP_EN makes columns 127 and 0 adjacent.
module sprite_tile_mover
    import pacman_map_pkg::*;
#(
    parameter int TILE_SHIFT  = pacman_map_pkg::TILE_SHIFT,
    parameter int START_IDX_X = 1,
    parameter int START_IDX_Y = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               move_tick,
    input  logic               freeze,
    input  logic               target_valid,
    output logic               target_ready,
    input  logic [IDX_X_W-1:0] target_idx_x,
    input  logic [IDX_Y_W-1:0] target_idx_y,
    output logic [POS_X_W-1:0] pos_x,
    output logic [POS_Y_W-1:0] pos_y,
    output logic [IDX_X_W-1:0] curr_idx_x,
    output logic [IDX_Y_W-1:0] curr_idx_y,
    output logic               moving,
    output logic               arrived,
    output logic               target_err
);

    localparam logic [TILE_SHIFT:0] STEPS   = {1'b1, {TILE_SHIFT{1'b0}}};
    localparam logic [TILE_SHIFT:0] CNT_ONE = {{TILE_SHIFT{1'b0}}, 1'b1};
    localparam logic [IDX_X_W-1:0]  START_X = IDX_X_W'(START_IDX_X);
    localparam logic [IDX_Y_W-1:0]  START_Y = IDX_Y_W'(START_IDX_Y);

    state_e              state_q;
    dir_e                dir_q, dir_d;
    logic                bad_d;
    logic [TILE_SHIFT:0] cnt_q;
    logic [IDX_X_W-1:0]  tgt_x_q, curr_x_q;
    logic [IDX_Y_W-1:0]  tgt_y_q, curr_y_q;
    logic [POS_X_W-1:0]  pos_x_q, start_pos_x;
    logic [POS_Y_W-1:0]  pos_y_q, start_pos_y;
    logic                moving_q, arrived_q, err_q;
    logic                x_same, x_inc, x_dec, y_same, y_inc, y_dec;
    logic signed [IDX_Y_W:0] dy;

    sprite_tile_mover_map_index_to_display_pos #(.TILE_SHIFT(TILE_SHIFT)) u_start_pos (
        .idx_x (START_X),
        .idx_y (START_Y),
        .pos_x (start_pos_x),
        .pos_y (start_pos_y)
    );

`ifdef SPRITE_TUNNEL_WRAP_EN
    // Column difference taken modulo 128 so the tunnel edges are neighbours.
    logic [IDX_X_W-1:0] dx_mod;
    assign dx_mod = target_idx_x - curr_x_q;
    assign x_inc  = (dx_mod == {{(IDX_X_W-1){1'b0}}, 1'b1});
    assign x_dec  = (dx_mod == '1);
`else
    logic signed [IDX_X_W:0] dx;
    assign dx    = $signed({1'b0, target_idx_x}) - $signed({1'b0, curr_x_q});
    assign x_inc = (dx == 8'sd1);
    assign x_dec = (dx == '1);
`endif

    assign dy     = $signed({1'b0, target_idx_y}) - $signed({1'b0, curr_y_q});
    assign y_inc  = (dy == 7'sd1);
    assign y_dec  = (dy == '1);
    assign x_same = (target_idx_x == curr_x_q);
    assign y_same = (target_idx_y == curr_y_q);

    always_comb begin
        dir_d = DIR_NONE;
        bad_d = 1'b0;
        if (x_same && y_same)      dir_d = DIR_NONE;
        else if (x_inc && y_same)  dir_d = DIR_E;
        else if (x_dec && y_same)  dir_d = DIR_W;
        else if (x_same && y_inc)  dir_d = DIR_S;
        else if (x_same && y_dec)  dir_d = DIR_N;
        else                       bad_d = 1'b1;
    end

    assign target_ready = (state_q == ST_IDLE) && !freeze;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_NONE;
            cnt_q     <= '0;
            tgt_x_q   <= START_X;
            tgt_y_q   <= START_Y;
            curr_x_q  <= START_X;
            curr_y_q  <= START_Y;
            pos_x_q   <= start_pos_x;
            pos_y_q   <= start_pos_y;
            moving_q  <= 1'b0;
            arrived_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            arrived_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (target_valid && target_ready) begin
                        if (bad_d) begin
                            err_q <= 1'b1;
                        end else if (dir_d == DIR_NONE) begin
                            arrived_q <= 1'b1;
                        end else begin
                            dir_q    <= dir_d;
                            tgt_x_q  <= target_idx_x;
                            tgt_y_q  <= target_idx_y;
                            cnt_q    <= STEPS;
                            moving_q <= 1'b1;
                            state_q  <= ST_MOVE;
                        end
                    end
                end
                ST_MOVE: begin
                    if (move_tick && !freeze) begin
                        case (dir_q)
                            DIR_E:   pos_x_q <= pos_x_q + 11'd1;
                            DIR_W:   pos_x_q <= pos_x_q - 11'd1;
                            DIR_S:   pos_y_q <= pos_y_q + 10'd1;
                            DIR_N:   pos_y_q <= pos_y_q - 10'd1;
                            default: ;
                        endcase
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            curr_x_q  <= tgt_x_q;
                            curr_y_q  <= tgt_y_q;
                            arrived_q <= 1'b1;
                            moving_q  <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign curr_idx_x = curr_x_q;
    assign curr_idx_y = curr_y_q;
    assign moving     = moving_q;
    assign arrived    = arrived_q;
    assign target_err = err_q;

endmodule

// File: tb/tb_sprite_tile_mover.sv
// Directed bench for sprite_tile_mover; tunnel expectations follow SPRITE_TUNNEL_WRAP_EN.
module tb_sprite_tile_mover;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        move_tick = 1'b0;
    logic        freeze = 1'b0;
    logic        target_valid = 1'b0;
    logic        target_ready;
    logic [6:0]  target_idx_x = '0;
    logic [5:0]  target_idx_y = '0;
    logic [10:0] pos_x;
    logic [9:0]  pos_y;
    logic [6:0]  curr_idx_x;
    logic [5:0]  curr_idx_y;
    logic        moving, arrived, target_err;

    int n_checks = 0;
    int n_errors = 0;
    int cx;

    sprite_tile_mover #(.TILE_SHIFT(4), .START_IDX_X(1), .START_IDX_Y(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .move_tick    (move_tick),
        .freeze       (freeze),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .target_idx_x (target_idx_x),
        .target_idx_y (target_idx_y),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .curr_idx_x   (curr_idx_x),
        .curr_idx_y   (curr_idx_y),
        .moving       (moving),
        .arrived      (arrived),
        .target_err   (target_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
    endtask

    task automatic offer(input int x, input int y);
        target_idx_x = 7'(x);
        target_idx_y = 6'(y);
        target_valid = 1'b1;
        step();
        target_valid = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_pos_x", pos_x, 16);
        check("rst_pos_y", pos_y, 16);
        check("rst_cx", curr_idx_x, 1);
        check("rst_cy", curr_idx_y, 1);
        check("rst_ready", target_ready, 1);
        check("rst_moving", moving, 0);
        check("rst_arrived", arrived, 0);
        check("rst_err", target_err, 0);

        // East move, ticks every third cycle
        offer(2, 1);
        check("e_moving", moving, 1);
        check("e_ready", target_ready, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("e_pos_x", pos_x, 32'(16 + k));
            if (k == 16) begin
                check("e_arrived", arrived, 1);
                check("e_cx", curr_idx_x, 2);
                check("e_cy", curr_idx_y, 1);
                check("e_moving_end", moving, 0);
                check("e_ready_end", target_ready, 1);
            end else begin
                check("e_no_arr", arrived, 0);
                step();
                step();
            end
        end
        step();
        check("e_arr_pulse", arrived, 0);

        // Non-adjacent target
        offer(3, 3);
        check("err_pulse", target_err, 1);
        check("err_pos_x", pos_x, 32);
        check("err_pos_y", pos_y, 16);
        check("err_moving", moving, 0);
        check("err_cx", curr_idx_x, 2);
        step();
        check("err_clear", target_err, 0);

        // Same tile: arrive immediately, no movement
        offer(2, 1);
        check("same_arr", arrived, 1);
        check("same_moving", moving, 0);
        check("same_err", target_err, 0);

        // North move with a freeze window
        offer(2, 0);
        repeat (5) begin tick(); step(); end
        check("frz_pre", pos_y, 11);
        freeze = 1'b1;
        repeat (4) begin tick(); step(); end
        check("frz_hold", pos_y, 11);
        check("frz_moving", moving, 1);
        check("frz_ready", target_ready, 0);
        freeze = 1'b0;
        repeat (10) begin tick(); step(); end
        check("frz_pos10", pos_y, 1);
        check("frz_no_arr", arrived, 0);
        tick();
        check("frz_pos11", pos_y, 0);
        check("frz_arr", arrived, 1);
        check("frz_cy", curr_idx_y, 0);

        // Back-to-back targets with valid held
        step();
        target_idx_x = 7'd3;
        target_idx_y = 6'd0;
        target_valid = 1'b1;
        step();
        check("b2b_acc1", moving, 1);
        target_idx_x = 7'd4;
        repeat (16) tick();
        check("b2b_arr1", arrived, 1);
        check("b2b_ready", target_ready, 1);
        check("b2b_pos1", pos_x, 48);
        check("b2b_cx1", curr_idx_x, 3);
        step();
        check("b2b_acc2", moving, 1);
        check("b2b_arr_clr", arrived, 0);
        target_valid = 1'b0;
        repeat (16) tick();
        check("b2b_pos2", pos_x, 64);
        check("b2b_cx2", curr_idx_x, 4);
        check("b2b_arr2", arrived, 1);

        // Walk west to column 0
        for (int c = 3; c >= 0; c--) begin
            offer(c, 0);
            repeat (16) tick();
            check("w_cx", curr_idx_x, 32'(c));
        end
        check("w_pos_x", pos_x, 0);

        // Tunnel edge
        offer(127, 0);
`ifdef SPRITE_TUNNEL_WRAP_EN
        check("tun_moving", moving, 1);
        tick();
        check("tun_wrap", pos_x, 2047);
        repeat (15) tick();
        check("tun_pos", pos_x, 2032);
        check("tun_cx", curr_idx_x, 127);
        check("tun_arr", arrived, 1);
        cx = 127;
`else
        check("tun_err", target_err, 1);
        check("tun_moving", moving, 0);
        check("tun_pos", pos_x, 0);
        check("tun_cx", curr_idx_x, 0);
        cx = 0;
`endif

        // Freeze in idle blocks the handshake
        step();
        freeze = 1'b1;
        #1;
        check("fidle_ready", target_ready, 0);
        target_idx_x = 7'(cx);
        target_idx_y = 6'd1;
        target_valid = 1'b1;
        step();
        check("fidle_moving", moving, 0);
        target_valid = 1'b0;
        freeze = 1'b0;
        #1;
        check("fidle_ready_rel", target_ready, 1);

        // Reset mid-move
        offer(cx, 1);
        repeat (3) tick();
        check("rmm_pre", pos_y, 3);
        rst = 1'b1;
        #1;
        check("rmm_pos_x", pos_x, 16);
        check("rmm_pos_y", pos_y, 16);
        check("rmm_cx", curr_idx_x, 1);
        check("rmm_cy", curr_idx_y, 1);
        check("rmm_moving", moving, 0);
        step();
        rst = 1'b0;
        repeat (3) tick();
        check("rmm_discard", pos_y, 16);
        check("rmm_idle", moving, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_tile_mover.md
# sprite_tile_mover

Converts tile-level move commands (matrix indices) into pixel-accurate display positions for one sprite (ghost or pacman), the inverse of the display-to-map-index path used by collision detection. A controller hands over the next orthogonally adjacent tile via a valid/ready handshake. The block then steps the sprite's display position one pixel per `move_tick` until the sprite sits on the target tile, and reports arrival. Its `pos_x`/`pos_y` outputs feed the renderer and collision detection directly.

## Interface
- `TILE_SHIFT`, 4: log2 of tile size in pixels (16 px tiles).
- `START_IDX_X`, 1: column index after reset.
- `START_IDX_Y`, 1: row index after reset.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `move_tick` in 1: single-cycle pulse; one pixel step per pulse while moving.
- `freeze` in 1: hold everything (e.g. `pacman_is_dead` asserted).
- `target_valid` in 1: target tile offered.
- `target_ready` out 1: block can accept a target.
- `target_idx_x` in 7: target column.
- `target_idx_y` in 6: target row.
- `pos_x` out 11: sprite display x, top-left pixel.
- `pos_y` out 10: sprite display y, top-left pixel.
- `curr_idx_x` out 7: last fully reached column.
- `curr_idx_y` out 6: last fully reached row.
- `moving` out 1: high in MOVE state.
- `arrived` out 1: one-cycle pulse when the target is reached.
- `target_err` out 1: one-cycle pulse when a rejected target is consumed.

## Operation
- Reset values:
  - `pos_x = START_IDX_X << TILE_SHIFT`, `pos_y = START_IDX_Y << TILE_SHIFT`.
  - `curr_idx` = START values.
  - State IDLE; `moving`, `arrived`, `target_err` all 0.
- FSM IDLE:
  - `target_ready = !freeze`.
  - Accept on `target_valid && target_ready`.
  - Target is decoded against `curr_idx`:
    - dx=±1, dy=0 → direction E/W.
    - dx=0, dy=±1 → direction S/N.
    - dx=dy=0 → no movement; `arrived` pulses next cycle, stay IDLE.
    - Anything else → `target_err` pulses next cycle, stay IDLE, no state change.
  - Valid move: latch target and direction, load step counter = `2^TILE_SHIFT`, go to MOVE.
- FSM MOVE:
  - `target_ready = 0`.
  - Each cycle with `move_tick && !freeze`: position advances 1 px in the latched direction and the counter decrements.
  - On the step that brings the counter to 0, in the same edge: `curr_idx <= latched target`, `arrived <= 1`, state ← IDLE.
  - `move_tick` while `freeze=1` is dropped, not queued.
- Arithmetic:
  - `pos_x` and `pos_y` are unsigned and wrap modulo 2^11 / 2^10.
  - Index compare uses 8-bit / 7-bit signed differences.
- Reset mid-move: immediate return to reset values; the latched target is discarded.

## Timing
- Handshake accept at edge N → `moving=1` and `target_ready=0` visible after edge N.
- Pixel step is registered: a tick sampled at edge N updates `pos` after edge N.
- Full tile move takes exactly 16 accepted ticks.
- `arrived` is high in the cycle after the final step. `target_ready` returns high in that same cycle, so back-to-back targets can be accepted with zero idle gap.
- Outputs are all registered; no combinational input-to-output path except `target_ready` from `freeze`.

## Configuration
- `SPRITE_TUNNEL_WRAP_EN` defined:
  - Column 127 and column 0 count as adjacent (dx computed modulo 128).
  - E from 127 steps `pos_x` 2047→0 and lands on index 0; W from 0 lands on 127.
- Not defined: 127↔0 is non-adjacent and produces `target_err`.
- Rows never wrap in either configuration.

## Structure
- Package `pacman_map_pkg` holds:
  - `TILE_SHIFT` and the index/position widths (7/6, 11/10).
  - Direction enum (`DIR_N`, `DIR_S`, `DIR_E`, `DIR_W`, `DIR_NONE`).
  - FSM state enum (`ST_IDLE`, `ST_MOVE`).
- Sub-module `_map_index_to_display_pos` (combinational, idx → pixel shift) computes the reset and start positions. It is shared with the renderer and is the inverse of `_display_pos_to_map_index`.

## Test plan
- Reset with START=(1,1) → `pos`=(16,16), `curr_idx`=(1,1), `target_ready`=1, no pulses.
- Target (2,1), 16 ticks spaced 3 cycles → `pos_x` 16→32 in 1-px steps. `arrived` pulses one cycle after the 16th tick; `curr_idx`=(2,1).
- Target (3,3) from (1,1) → `target_err` pulse, `pos` unchanged, `moving`=0.
- Assert `freeze` after 5 ticks of a N move, send 4 ticks, then deassert → `pos_y` frozen at 11. After release, 11 more ticks are needed to arrive.
- Back-to-back targets (2,1) then (3,1) with `target_valid` held → second accepted in the `arrived` cycle; `pos_x` reaches 48 after 32 ticks.
- With `SPRITE_TUNNEL_WRAP_EN`: start (127,1), target (0,1) → `pos_x` 2032→2047→0→0 after 16 ticks, arrives at index 0. Without the macro → `target_err`.
